// File: rtl/inst_fetch_prefetch_if.sv
// Instruction-memory fetch port: req/gnt request channel plus in-order rvalid response channel.
interface inst_fetch_prefetch_if;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_addr_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/inst_fetch_prefetch.sv
// Instruction prefetch queue between a variable-latency imem port and IF/ID; redirects flush and drop stale responses.
// Optional PREFETCH_BYPASS_EN: an rvalid into an empty queue drives the head outputs in the same cycle.
module inst_fetch_prefetch #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    inst_fetch_prefetch_if.master mem
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;
    typedef enum logic {RUN, FLUSH} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    cnt_t        count_q, count_d;
    cnt_t        outst_q, outst_d;
    cnt_t        discard_q, discard_d;
    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    cnt_t inflight;
    logic run, req, accept, rsp, live_rsp, q_valid, push, pop;

    assign mem.mem_req_o  = req;
    assign mem.mem_addr_o = fetch_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        head_d     = head_q;
        tail_d     = tail_q;

        // Only one of outst/discard is non-zero at a time: RUN tracks live fetches, FLUSH stale ones.
        inflight = outst_q + discard_q;
        run      = (state_q == RUN);
        req      = rst_n && run && !redirect_i &&
                   (({1'b0, count_q} + {1'b0, outst_q}) < (CW + 1)'(DEPTH));
        accept   = req && mem.mem_gnt_i;
        rsp      = mem.mem_rvalid_i && (inflight != '0);
        live_rsp = run && !redirect_i && rsp;
        q_valid  = (count_q != '0);

        valid_o = q_valid;
        instr_o = q_valid ? instr_mem[head_q] : NOP_INSTR;
        pc_o    = q_valid ? pc_mem[head_q] : '0;
        push    = live_rsp;
`ifdef PREFETCH_BYPASS_EN
        if (!q_valid && live_rsp) begin
            valid_o = 1'b1;
            instr_o = mem.mem_rdata_i;
            pc_o    = resp_pc_q;
            push    = stall_i;
        end
`endif
        pc_plus4_o = valid_o ? (pc_o + 32'd4) : '0;
        pop        = q_valid && !stall_i && !redirect_i;

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ~32'd3;
            resp_pc_d  = redirect_pc_i & ~32'd3;
            count_d    = '0;
            outst_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            discard_d  = inflight - cnt_t'(rsp);
            state_d    = (discard_d != '0) ? FLUSH : RUN;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
            outst_d = outst_q + cnt_t'(accept) - cnt_t'(live_rsp);
            if (live_rsp) resp_pc_d = resp_pc_q + 32'd4;
            if (!run && rsp) begin
                discard_d = discard_q - cnt_t'(1);
                if (discard_d == '0) state_d = RUN;
            end
            if (push) tail_d = tail_q + ptr_t'(1);
            if (pop)  head_d = head_q + ptr_t'(1);
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC & ~32'd3;
            resp_pc_q  <= RESET_PC & ~32'd3;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail_q] <= mem.mem_rdata_i;
            pc_mem[tail_q]    <= resp_pc_q;
        end
    end

    // A response with nothing in flight is a memory-side protocol violation.
    assert property (@(posedge clk) disable iff (!rst_n) !(mem.mem_rvalid_i && (inflight == '0)));
endmodule

// File: tb/tb_inst_fetch_prefetch.sv
// Bench for inst_fetch_prefetch: random memory timing against a stream-level model (pending fetches, delivered PCs).
module tb_inst_fetch_prefetch;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, redirect_i, stall_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic [31:0] instr_o, pc_o, pc_plus4_o;

    inst_fetch_prefetch_if mif ();

    inst_fetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .stall_i(stall_i), .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o),
        .pc_plus4_o(pc_plus4_o), .mem(mif)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int unsigned ep; longint unsigned due; } pend_t;
    pend_t            pend[$];
    logic [31:0]      expq[$];
    logic [31:0]      fetch_m, last_pop;
    int unsigned      epoch;
    longint unsigned  cyc;
    int unsigned      gnt_pct, stall_pct, redir_pct, lat_lo, lat_hi;
    bit               want_combo, wrap_seen;
    int unsigned      cmp_n, err_n, accepts, pops, combo_hits;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic int unsigned n_cur();
        int unsigned n = 0;
        foreach (pend[i]) if (pend[i].ep == epoch) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_instr", instr_o, NOP);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_pc4", pc_plus4_o, 32'd0);
        chk("rst_req", 32'(mif.mem_req_o), 32'd0);
        chk("rst_addr", mif.mem_addr_o, RST_PC);
    endtask

    task automatic drive();
        mif.mem_gnt_i    = ($urandom_range(99) < gnt_pct);
        mif.mem_rvalid_i = (pend.size() != 0) && (pend[0].due <= cyc);
        mif.mem_rdata_i  = mif.mem_rvalid_i ? rd(pend[0].addr) : $urandom();
        stall_i          = ($urandom_range(99) < stall_pct);
        redirect_i       = ($urandom_range(99) < redir_pct);
        redirect_pc_i    = $urandom();
        if (want_combo && expq.size() == 2 && mif.mem_rvalid_i) begin
            redirect_i = 1'b1;
            stall_i    = 1'b0;
            combo_hits++;
        end
    endtask

    // One clock: check outputs at negedge, advance the model at posedge, drive next inputs.
    task automatic cycle();
        int unsigned     stale, curp;
        bit              ereq, evalid, acc, pop, rv;
        logic [31:0]     head;
        longint unsigned due;
        pend_t           f;
        f = '{addr: '0, ep: 0, due: 0};
        @(negedge clk);
        stale = 0;
        curp  = 0;
        foreach (pend[i]) if (pend[i].ep == epoch) curp++; else stale++;
        rv     = mif.mem_rvalid_i;
        ereq   = (stale == 0) && !redirect_i && (curp + expq.size() < DEPTH);
        evalid = (expq.size() != 0);
        head   = evalid ? expq[0] : '0;
`ifdef PREFETCH_BYPASS_EN
        if (!evalid && stale == 0 && !redirect_i && rv) begin
            evalid = 1'b1;
            head   = pend[0].addr;
        end
`endif
        chk("mem_req", 32'(mif.mem_req_o), 32'(ereq));
        chk("mem_addr", mif.mem_addr_o, fetch_m);
        chk("valid", 32'(valid_o), 32'(evalid));
        if (evalid) begin
            chk("head_pc", pc_o, head);
            chk("head_instr", instr_o, rd(head));
            chk("head_pc4", pc_plus4_o, head + 32'd4);
        end else begin
            chk("idle_instr", instr_o, NOP);
            chk("idle_pc", pc_o, 32'd0);
            chk("idle_pc4", pc_plus4_o, 32'd0);
        end
        acc = ereq && mif.mem_gnt_i;
        pop = evalid && !stall_i && !redirect_i;
        @(posedge clk);
        cyc++;
        if (rv) f = pend.pop_front();
        if (redirect_i) begin
            epoch++;
            fetch_m = redirect_pc_i & ~32'd3;
            expq.delete();
        end else begin
            if (rv && f.ep == epoch) expq.push_back(f.addr);
            if (pop) begin
                last_pop = expq.pop_front();
                pops++;
                if (last_pop == 32'hFFFF_FFFC) wrap_seen = 1'b1;
            end
            if (acc) begin
                due = cyc + longint'($urandom_range(lat_hi, lat_lo)) - 1;
                if (pend.size() != 0 && pend[$].due > due) due = pend[$].due;
                pend.push_back('{addr: fetch_m, ep: epoch, due: due});
                fetch_m += 32'd4;
                accepts++;
            end
        end
        #1;
        drive();
    endtask

    task automatic apply_reset(input int unsigned n);
        rst_n = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            mif.mem_rvalid_i = 1'($urandom_range(1));
            mif.mem_rdata_i  = $urandom();
            mif.mem_gnt_i    = 1'($urandom_range(1));
        end
        pend.delete();
        expq.delete();
        fetch_m = RST_PC;
        epoch++;
        mif.mem_rvalid_i = 1'b0;
        mif.mem_gnt_i    = 1'b1;
        redirect_i       = 1'b0;
        stall_i          = 1'b0;
        rst_n            = 1'b1;
    endtask

    initial begin
        logic [31:0] first_pc;
        int unsigned p0;
        cmp_n = 0; err_n = 0; accepts = 0; pops = 0; combo_hits = 0;
        epoch = 0; cyc = 0; fetch_m = RST_PC; last_pop = '0;
        wrap_seen = 1'b0; want_combo = 1'b0;
        rst_n = 1'b0; redirect_i = 1'b0; stall_i = 1'b0; redirect_pc_i = '0;
        mif.mem_gnt_i = 1'b0; mif.mem_rvalid_i = 1'b0; mif.mem_rdata_i = '0;
        gnt_pct = 100; stall_pct = 0; redir_pct = 0; lat_lo = 1; lat_hi = 1;

        #3;
        chk_reset_outs();
        apply_reset(2);
        repeat (20) cycle();

        // Stalled consumer: exactly DEPTH fetches, then no requests until pops resume.
        apply_reset(2);
        stall_pct = 100;
        stall_i   = 1'b1;
        accepts   = 0;
        repeat (10) cycle();
        chk("stall_accepts", accepts, DEPTH);
        chk("stall_head_pc", pc_o, RST_PC);
        stall_pct = 0;
        stall_i   = 1'b0;
        pops      = 0;
        repeat (20) cycle();
        chk("post_stall_pops", 32'(pops >= 5), 32'd1);

        // Redirect with three fetches in flight at latency 3.
        lat_lo = 3; lat_hi = 3;
        for (int k = 0; k < 20 && n_cur() != 3; k++) cycle();
        chk("three_outstanding", n_cur(), 32'd3);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        stall_i       = 1'b0;
        p0 = pops;
        cycle();
        chk("flush_valid", 32'(valid_o), 32'd0);
        for (int k = 0; k < 40 && pops == p0; k++) cycle();
        first_pc = (pops != p0) ? last_pop : 32'hDEAD_DEAD;
        chk("first_pc_after_redirect", first_pc, 32'h0000_0100);

        // Address wrap at the top of the address space.
        lat_lo = 1; lat_hi = 2;
        wrap_seen     = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF1;
        cycle();
        repeat (30) cycle();
        chk("wrap_seen", 32'(wrap_seen), 32'd1);

        // Random traffic including redirect coinciding with rvalid and pop at count 2.
        gnt_pct = 70; stall_pct = 30; redir_pct = 4; lat_lo = 1; lat_hi = 4;
        want_combo = 1'b1;
        drive();
        repeat (500) cycle();
        want_combo = 1'b0;
        chk("combo_hit", 32'(combo_hits > 0), 32'd1);

        // Asynchronous reset in the middle of a burst.
        gnt_pct = 100; stall_pct = 100; redir_pct = 0; lat_lo = 3; lat_hi = 3;
        for (int k = 0; k < 30 && n_cur() < 2; k++) cycle();
        chk("mid_burst_outstanding", 32'(n_cur() >= 2), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs();
        apply_reset(3);
        stall_pct = 0; lat_lo = 1; lat_hi = 2;
        repeat (20) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
